matrix_stream_loader: RTL and testbench

Receiving end of the element-strobe handshake. It accepts a serial stream of 32-bit matrix elements from a producer, one element per strobe/ack exchange, and stores them in an internal m×m buffer, row-major or transposed. It then exposes the buffer through an (i, j) random-access read port of the same shape as the multiplier's a_in/b_in operand ports. Two instances feed the A and B operands of sequential_matrix_multiplier, replacing file-based preload.

---
 rtl/matrix_stream_loader.sv | 157 +++++++++++++++
 tb/tb_matrix_stream_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_loader.sv
// Receives a strobe/ack stream of 32-bit elements into an m x m buffer (row-major or
// transposed) and serves it through a registered (i, j) random-access read port.
module matrix_stream_loader #(
  parameter int m         = 4,
  parameter int m_len     = $clog2(m),
  parameter bit TRANSPOSE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      in_data,
  input  logic             in_stb,
  output logic             in_ack,
  output logic [m_len-1:0] wr_i,
  output logic [m_len-1:0] wr_j,
  input  logic [m_len-1:0] rd_i,
  input  logic [m_len-1:0] rd_j,
  output logic [31:0]      rd_data,
  output logic             loaded
);

  localparam int N   = m * m;
  localparam int K_W = $clog2(N + 1);
  localparam logic [K_W-1:0]   LAST_K   = K_W'(N - 1);
  localparam logic [m_len-1:0] LAST_COL = m_len'(m - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [m_len-1:0] row_q, row_d;
  logic [m_len-1:0] col_q, col_d;
  logic             ack_q, ack_d;
  logic             loaded_q, loaded_d;
  logic [31:0]      rd_data_q;
  logic [31:0]      buf_q [0:m-1][0:m-1];

  logic             capture_s;
  logic [m_len-1:0] wr_row_s;
  logic [m_len-1:0] wr_col_s;
  logic [31:0]      rd_word_s;

  // row_q/col_q are k/m and k%m kept as counters; TRANSPOSE only swaps them.
  assign wr_row_s = TRANSPOSE ? col_q : row_q;
  assign wr_col_s = TRANSPOSE ? row_q : col_q;

  // Next-state, element counter and acknowledge generation.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    row_d     = row_q;
    col_d     = col_q;
    ack_d     = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          k_d     = '0;
          row_d   = '0;
          col_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        // ack_q blocks the strobe still held from the previous exchange.
        if (in_stb && !ack_q) begin
          capture_s = 1'b1;
          ack_d     = 1'b1;
          if (k_q == LAST_K) begin
            state_d = FULL;
            k_d     = '0;
            row_d   = '0;
            col_d   = '0;
          end else begin
            k_d = k_q + K_W'(1);
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + m_len'(1);
            end else begin
              col_d = col_q + m_len'(1);
            end
          end
        end else begin
          state_d = LOAD;
        end
      end
      FULL: begin
        if (start) begin
          state_d = LOAD;
          k_d     = '0;
          row_d   = '0;
          col_d   = '0;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
        row_d   = '0;
        col_d   = '0;
      end
    endcase
    loaded_d = (state_d == FULL);
  end

  // Read-port word select; out-of-range coordinates read as zero.
  always_comb begin
    if ((int'(rd_i) < m) && (int'(rd_j) < m)) begin
      rd_word_s = buf_q[rd_i][rd_j];
    end else begin
      rd_word_s = 32'h0000_0000;
    end
  end

  // State, counters, buffer and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      ack_q     <= 1'b0;
      loaded_q  <= 1'b0;
      rd_data_q <= 32'h0000_0000;
      for (int i = 0; i < m; i++) begin
        for (int j = 0; j < m; j++) begin
          buf_q[i][j] <= 32'h0000_0000;
        end
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ack_q     <= ack_d;
      loaded_q  <= loaded_d;
      rd_data_q <= rd_word_s;
      if (capture_s) begin
        buf_q[wr_row_s][wr_col_s] <= in_data;
      end
    end
  end

  assign in_ack  = ack_q;
  assign loaded  = loaded_q;
  assign rd_data = rd_data_q;
  assign wr_i    = wr_row_s;
  assign wr_j    = wr_col_s;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Self-checking bench: row-major and transposed loaders driven by one producer,
// compared against an array model indexed directly by element number.
module tb_matrix_stream_loader;

  logic        clk, rst, start, in_stb;
  logic [31:0] in_data;
  logic [1:0]  rd_i, rd_j;
  logic        in_ack0, in_ack1, loaded0, loaded1;
  logic [1:0]  wr_i0, wr_j0, wr_i1, wr_j1;
  logic [31:0] rd_data0, rd_data1;

  matrix_stream_loader #(.m(4), .TRANSPOSE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_stb(in_stb),
    .in_ack(in_ack0), .wr_i(wr_i0), .wr_j(wr_j0), .rd_i(rd_i), .rd_j(rd_j),
    .rd_data(rd_data0), .loaded(loaded0));

  matrix_stream_loader #(.m(4), .TRANSPOSE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_stb(in_stb),
    .in_ack(in_ack1), .wr_i(wr_i1), .wr_j(wr_j1), .rd_i(rd_i), .rd_j(rd_j),
    .rd_data(rd_data1), .loaded(loaded1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;

  // Counts cycles in which the acknowledge is high.
  always @(negedge clk) if (in_ack0 === 1'b1) ack_cnt <= ack_cnt + 1;

  // Reference model: element k lands at [k/4][k%4] (row-major) or [k%4][k/4].
  logic [31:0] exp0 [4][4];
  logic [31:0] exp1 [4][4];
  int          mk;
  bit          mloaded;

  typedef struct {
    int          ri;
    int          rj;
    logic [31:0] e0;
    logic [31:0] e1;
  } rd_vec_t;
  rd_vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        exp0[i][j] = 32'h0;
        exp1[i][j] = 32'h0;
      end
    mk = 0;
    mloaded = 1'b0;
  endtask

  task automatic model_start();
    mk = 0;
    mloaded = 1'b0;
  endtask

  task automatic model_write(input logic [31:0] d);
    exp0[mk / 4][mk % 4] = d;
    exp1[mk % 4][mk / 4] = d;
    mk++;
    if (mk == 16) begin
      mk = 0;
      mloaded = 1'b1;
    end
  endtask

  task automatic chk_wr();
    chk("wr_i0", 32'(wr_i0), 32'(mk / 4));
    chk("wr_j0", 32'(wr_j0), 32'(mk % 4));
    chk("wr_i1", 32'(wr_i1), 32'(mk % 4));
    chk("wr_j1", 32'(wr_j1), 32'(mk / 4));
  endtask

  task automatic rd_check(input int i, input int j);
    rd_i = 2'(i);
    rd_j = 2'(j);
    tick();
    chk("rd0", rd_data0, exp0[i][j]);
    chk("rd1", rd_data1, exp1[i][j]);
  endtask

  task automatic rd_all();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) rd_check(i, j);
  endtask

  // Offers one element and waits (bounded) for its acknowledge.
  task automatic send(input logic [31:0] d, input bit hold, output int waited);
    chk_wr();
    in_data = d;
    in_stb  = 1'b1;
    waited  = 0;
    do begin
      tick();
      waited++;
    end while (in_ack0 !== 1'b1 && waited < 20);
    if (in_ack0 !== 1'b1) begin
      chk("ack_timeout", 32'(in_ack0), 32'd1);
      in_stb = 1'b0;
    end else begin
      chk("ack_pair", 32'(in_ack1), 32'd1);
      model_write(d);
      chk("loaded0", 32'(loaded0), 32'(mloaded));
      chk("loaded1", 32'(loaded1), 32'(mloaded));
      if (!hold) in_stb = 1'b0;
    end
  endtask

  // Idle cycles inside a load: random reads and ignored start pulses.
  task automatic gap(input int n);
    for (int g = 0; g < n; g++) begin
      int ri, rj;
      ri = $urandom_range(0, 3);
      rj = $urandom_range(0, 3);
      rd_i  = 2'(ri);
      rd_j  = 2'(rj);
      start = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
      chk("gap_rd0", rd_data0, exp0[ri][rj]);
      chk("gap_rd1", rd_data1, exp1[ri][rj]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_start();
  endtask

  task automatic random_load(input bit hold);
    int w;
    for (int k = 0; k < 16; k++) begin
      send($urandom, hold, w);
      if (!hold && k < 15) gap($urandom_range(0, 3));
    end
    in_stb = 1'b0;
    tick();
  endtask

  initial begin
    int a, w;
    logic [31:0] old00;
    tbl[0] = '{2, 3, 32'd11, 32'd14};
    tbl[1] = '{3, 0, 32'd12, 32'd3};
    tbl[2] = '{0, 1, 32'd1,  32'd4};
    tbl[3] = '{0, 0, 32'd0,  32'd0};
    tbl[4] = '{3, 3, 32'd15, 32'd15};
    tbl[5] = '{1, 2, 32'd6,  32'd9};

    rst = 1'b1; start = 1'b0; in_stb = 1'b0; in_data = 32'h0; rd_i = 2'd0; rd_j = 2'd0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ack", 32'(in_ack0), 32'd0);
    chk("rst_loaded", 32'(loaded0), 32'd0);
    chk_wr();
    chk("rst_rd0", rd_data0, 32'h0);
    chk("rst_rd1", rd_data1, 32'h0);

    // Strobe while idle: never acknowledged, buffer untouched.
    a = ack_cnt;
    in_stb = 1'b1; in_data = 32'hDEAD_BEEF;
    repeat (10) tick();
    in_stb = 1'b0;
    chk("idle_acks", 32'(ack_cnt - a), 32'd0);
    chk("idle_loaded", 32'(loaded0), 32'd0);
    rd_check(1, 1);

    // Load 0..15, producer drops the strobe after each ack.
    pulse_start();
    a = ack_cnt;
    for (int k = 0; k < 16; k++) send(32'(k), 1'b0, w);
    tick();
    chk("ack_count", 32'(ack_cnt - a), 32'd16);
    chk("full_loaded0", 32'(loaded0), 32'd1);
    chk("full_loaded1", 32'(loaded1), 32'd1);
    chk_wr();
    for (int t = 0; t < 6; t++) begin
      rd_i = 2'(tbl[t].ri);
      rd_j = 2'(tbl[t].rj);
      tick();
      chk("tbl_rd0", rd_data0, tbl[t].e0);
      chk("tbl_rd1", rd_data1, tbl[t].e1);
    end

    // start together with a strobe in FULL; then a held strobe stream.
    start = 1'b1; in_stb = 1'b1; in_data = 32'hA5A5_0000;
    tick();
    start = 1'b0;
    model_start();
    chk("restart_loaded", 32'(loaded0), 32'd0);
    chk("restart_noack", 32'(in_ack0), 32'd0);
    for (int k = 0; k < 16; k++) begin
      send(32'hA5A5_0000 + 32'(k), 1'b1, w);
      chk("rate", 32'(w), (k == 0) ? 32'd1 : 32'd2);
    end
    in_data = 32'hA5A5_0010;
    tick();
    a = ack_cnt;
    repeat (6) tick();
    chk("bp_acks", 32'(ack_cnt - a), 32'd0);
    chk("bp_loaded", 32'(loaded0), 32'd1);
    in_stb = 1'b0;
    for (int r = 0; r < 8; r++) rd_check($urandom_range(0, 3), $urandom_range(0, 3));

    // Reset after 7 captures, with a capture-eligible strobe at the reset edge.
    pulse_start();
    for (int k = 0; k < 7; k++) send($urandom, 1'b0, w);
    tick();
    in_stb = 1'b1; in_data = 32'h1234_5678; rst = 1'b1;
    tick();
    rst = 1'b0; in_stb = 1'b0;
    model_reset();
    chk("midrst_ack", 32'(in_ack0), 32'd0);
    chk("midrst_loaded", 32'(loaded0), 32'd0);
    chk_wr();
    rd_all();
    pulse_start();
    random_load(1'b0);
    chk("reload_loaded", 32'(loaded1), 32'd1);
    rd_all();

    // Reload from FULL with 100..115; read-before-write on (0,0).
    old00 = exp0[0][0];
    rd_i = 2'd0; rd_j = 2'd0;
    pulse_start();
    chk("rl_loaded", 32'(loaded0), 32'd0);
    chk("rl_old00", rd_data0, old00);
    send(32'd100, 1'b0, w);
    chk("rbw_old00", rd_data0, old00);
    tick();
    chk("new00_0", rd_data0, 32'd100);
    chk("new00_1", rd_data1, 32'd100);
    for (int k = 101; k < 116; k++) begin
      send(32'(k), 1'b0, w);
      if (k < 115) gap($urandom_range(0, 2));
    end
    tick();
    chk("rl_done", 32'(loaded0), 32'd1);
    rd_all();

    // Random loads, held or released strobe.
    for (int r = 0; r < 3; r++) begin
      pulse_start();
      random_load(1'($urandom_range(0, 1)));
      rd_all();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
